alu_sequencer: RTL and testbench

Command sequencer for the 8-bit ALU select datapath. Accepts ALU commands (opcode plus two operands) through a valid/ready port into a small FIFO, drives the ALU's `select`/`a`/`b` inputs one command at a time, and captures the ALU result `x` into an accumulator and a result register. The result is returned through a valid/ready output. The ALU itself is instantiated beside this block; the sequencer is the only driver of its inputs.

---
 rtl/alu_seq_pkg.sv | 45 ++++
 rtl/alu_seq_fifo.sv | 51 +++++
 rtl/alu_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_sequencer shared package: ALU opcodes, FSM encoding, FIFO entry.
// Imported by alu_seq_fifo and alu_sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_A     = 4'd1;
  localparam logic [3:0] OP_B     = 4'd2;
  localparam logic [3:0] OP_NEG_A = 4'd3;
  localparam logic [3:0] OP_NEG_B = 4'd4;
  localparam logic [3:0] OP_ROR_A = 4'd5;
  localparam logic [3:0] OP_ROR_B = 4'd6;
  localparam logic [3:0] OP_LT    = 4'd7;
  localparam logic [3:0] OP_BITW  = 4'd8;
  localparam logic [3:0] OP_NOT_A = 4'd9;
  localparam logic [3:0] OP_NOT_B = 4'd10;
  localparam logic [3:0] OP_SUB   = 4'd11;
  localparam logic [3:0] OP_ADD   = 4'd12;

  localparam logic [3:0] OP_RESERVED_MIN = 4'd13;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ISSUE  = ST_ISSUE,
    S_RESULT = ST_RESULT
  } state_t;

  // 21-bit FIFO entry
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
  } cmd_t;

  function automatic logic is_reserved(
    input logic [3:0] op
  );
    return op >= OP_RESERVED_MIN;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: DEPTH-entry synchronous FIFO, sync active-low reset.
// Ports: push/din in, pop/dout (head, combinational), full, empty, count.
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  cmd_t                     din,
  input  logic                     pop,
  output cmd_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: queues ALU commands, drives ALU select/a/b, captures x.
// Ports: cmd_* in (valid/ready), alu_* out, alu_x in, res_* out
// (valid/ready), acc out. Define ALU_SEQ_FLAGS_EN to add res_zero/res_neg.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic [3:0] alu_select,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_x,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err,
`ifdef ALU_SEQ_FLAGS_EN
  output logic       res_zero,
  output logic       res_neg,
`endif
  output logic [7:0] acc
);

  cmd_t   din;
  cmd_t   head;
  logic   push;
  logic   pop;
  logic   full;
  logic   empty;
  logic   [$clog2(DEPTH):0] count;
  logic   unused_count;

  state_t state;
  state_t state_nxt;
  logic   rsv_q;

  assign din = '{
    op:      cmd_op,
    a:       cmd_a,
    b:       cmd_b,
    use_acc: cmd_use_acc
  };

  // registered count only: no path from pop or res_ready
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign res_valid = (state == S_RESULT);
  assign unused_count = ^count;

  alu_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_ISSUE;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // acc was written on the ISSUE edge, so a pop always sees it settled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_select <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsv_q      <= 1'b0;
    end else if (pop) begin
      alu_select <= is_reserved(head.op) ? OP_ZERO : head.op;
      alu_a      <= head.use_acc ? acc : head.a;
      alu_b      <= head.b;
      rsv_q      <= is_reserved(head.op);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data <= '0;
      res_err  <= 1'b0;
      acc      <= '0;
    end else if (state == S_ISSUE) begin
      if (rsv_q) begin
        res_data <= '0;
        res_err  <= 1'b1;
      end else begin
        res_data <= alu_x;
        res_err  <= 1'b0;
        acc      <= alu_x;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_zero <= 1'b0;
      res_neg  <= 1'b0;
    end else if (state == S_ISSUE) begin
      res_zero <= !rsv_q && (alu_x == 8'h00);
      res_neg  <= !rsv_q && alu_x[7];
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU beside it.
// Set ALU_SEQ_FLAGS_EN to also exercise res_zero/res_neg.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_use_acc;
  logic [3:0] alu_select;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_x;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;
`ifdef ALU_SEQ_FLAGS_EN
  logic       res_zero;
  logic       res_neg;
`endif
  logic [7:0] acc;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_use_acc (cmd_use_acc),
    .alu_select  (alu_select),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_x       (alu_x),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err),
`ifdef ALU_SEQ_FLAGS_EN
    .res_zero    (res_zero),
    .res_neg     (res_neg),
`endif
    .acc         (acc)
  );

  always_comb begin
    alu_x = 8'h00;
    case (alu_select)
      4'd1:    alu_x = alu_a;
      4'd2:    alu_x = alu_b;
      4'd3:    alu_x = 8'h00 - alu_a;
      4'd4:    alu_x = 8'h00 - alu_b;
      4'd5:    alu_x = {alu_a[0], alu_a[7:1]};
      4'd6:    alu_x = {alu_b[0], alu_b[7:1]};
      4'd7:    alu_x = {7'd0, alu_a < alu_b};
      4'd8:    alu_x = alu_a & alu_b;
      4'd9:    alu_x = ~alu_a;
      4'd10:   alu_x = ~alu_b;
      4'd11:   alu_x = alu_a - alu_b;
      4'd12:   alu_x = alu_a + alu_b;
      default: alu_x = 8'h00;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(
    input logic [3:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       ua
  );
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = ua;
    cmd_valid   = 1'b1;
    chk("push_ready", {7'd0, cmd_ready}, 8'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [6];
    int         got;
    logic       sixth;
    logic       take;

    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_a       = '0;
    cmd_b       = '0;
    cmd_use_acc = 1'b0;
    res_ready   = 1'b0;
    tick();
    tick();
    chk("rst_valid", {7'd0, res_valid}, 8'd0);
    chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_sel",   {4'd0, alu_select}, 8'd0);
    chk("rst_data",  res_data, 8'h00);
    chk("rst_acc",   acc, 8'h00);
    chk("rst_err",   {7'd0, res_err}, 8'd0);
    rst_n = 1'b1;
    tick();

    // single add: res_valid two edges after accept
    res_ready = 1'b1;
    push(4'd12, 8'h05, 8'h03, 1'b0);
    chk("s1_v0",  {7'd0, res_valid}, 8'd0);
    tick();
    chk("s1_sel", {4'd0, alu_select}, 8'd12);
    chk("s1_a",   alu_a, 8'h05);
    chk("s1_b",   alu_b, 8'h03);
    chk("s1_v1",  {7'd0, res_valid}, 8'd0);
    tick();
    chk("s1_v2",  {7'd0, res_valid}, 8'd1);
    chk("s1_dat", res_data, 8'h08);
    chk("s1_acc", acc, 8'h08);
    chk("s1_err", {7'd0, res_err}, 8'd0);
    tick();
    chk("s1_v3",  {7'd0, res_valid}, 8'd0);

    // accumulator chain
    push(4'd12, 8'h10, 8'h01, 1'b0);
    push(4'd12, 8'h00, 8'h01, 1'b1);
    tick();
    chk("ch_v1",  {7'd0, res_valid}, 8'd1);
    chk("ch_d1",  res_data, 8'h11);
    tick();
    chk("ch_gap", {7'd0, res_valid}, 8'd0);
    chk("ch_a2",  alu_a, 8'h11);
    tick();
    chk("ch_d2",  res_data, 8'h12);
    chk("ch_acc", acc, 8'h12);
    tick();

    // backpressure: 1 in flight + 4 queued, then drain in order
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(4'd1, 8'(8'h21 + i), 8'h00, 1'b0);
    end
    chk("bp_full", {7'd0, cmd_ready}, 8'd0);
    chk("bp_hold", {7'd0, res_valid}, 8'd1);
    chk("bp_d0",   res_data, 8'h21);
    cmd_op    = 4'd1;
    cmd_a     = 8'h26;
    cmd_b     = 8'h00;
    cmd_valid = 1'b1;
    tick();
    tick();
    chk("bp_full2", {7'd0, cmd_ready}, 8'd0);
    chk("bp_d0b",   res_data, 8'h21);
    for (int i = 0; i < 6; i++) exp_q[i] = 8'(8'h21 + i);
    got       = 0;
    sixth     = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 60 && got < 6; c++) begin
      take = cmd_valid && cmd_ready;
      if (res_valid) begin
        chk("bp_order", res_data, exp_q[got]);
        got++;
      end
      tick();
      if (take) begin
        cmd_valid = 1'b0;
        sixth     = 1'b1;
      end
    end
    chk("bp_count", 8'(got), 8'd6);
    chk("bp_sixth", {7'd0, sixth}, 8'd1);
    chk("bp_acc",   acc, 8'h26);

    // reserved opcode
    res_ready = 1'b0;
    push(4'd14, 8'hFF, 8'h00, 1'b0);
    tick();
    chk("rs_sel", {4'd0, alu_select}, 8'd0);
    chk("rs_a",   alu_a, 8'hFF);
    tick();
    chk("rs_v",   {7'd0, res_valid}, 8'd1);
    chk("rs_dat", res_data, 8'h00);
    chk("rs_err", {7'd0, res_err}, 8'd1);
    chk("rs_acc", acc, 8'h26);
    res_ready = 1'b1;
    tick();
    push(4'd2, 8'h00, 8'h5A, 1'b0);
    tick();
    tick();
    chk("rs_err2", {7'd0, res_err}, 8'd0);
    chk("rs_dat2", res_data, 8'h5A);
    chk("rs_acc2", acc, 8'h5A);
    tick();

    // reset in ISSUE with two entries queued
    res_ready = 1'b0;
    push(4'd12, 8'h01, 8'h01, 1'b0);
    push(4'd12, 8'h02, 8'h02, 1'b0);
    push(4'd12, 8'h03, 8'h03, 1'b0);
    cmd_op    = 4'd12;
    cmd_a     = 8'h04;
    cmd_b     = 8'h04;
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    chk("mr_a", alu_a, 8'h02);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_v",   {7'd0, res_valid}, 8'd0);
    chk("mr_sel", {4'd0, alu_select}, 8'd0);
    chk("mr_a0",  alu_a, 8'h00);
    chk("mr_b0",  alu_b, 8'h00);
    chk("mr_dat", res_data, 8'h00);
    chk("mr_acc", acc, 8'h00);
    chk("mr_rdy", {7'd0, cmd_ready}, 8'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mr_quiet", {7'd0, res_valid}, 8'd0);
    end
    chk("mr_sel2", {4'd0, alu_select}, 8'd0);

`ifdef ALU_SEQ_FLAGS_EN
    res_ready = 1'b1;
    push(4'd11, 8'h03, 8'h03, 1'b0);
    tick();
    tick();
    chk("fl_z1", {7'd0, res_zero}, 8'd1);
    chk("fl_n1", {7'd0, res_neg}, 8'd0);
    chk("fl_d1", res_data, 8'h00);
    tick();
    push(4'd11, 8'h01, 8'h02, 1'b0);
    tick();
    tick();
    chk("fl_z2", {7'd0, res_zero}, 8'd0);
    chk("fl_n2", {7'd0, res_neg}, 8'd1);
    chk("fl_d2", res_data, 8'hFF);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
